// File: rtl/psr_pkg.sv
// psr_pkg
// Shared definitions for the program status register block:
//   - processor mode encodings
//   - CPSR bit positions
//   - SPSR bank indices
//   - the default reset value
//   - small helpers for mode validity and byte-masked merges
package psr_pkg;

    // Mode encodings (cpsr[4:0])
    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // CPSR bit positions
    localparam int N_BIT   = 31;
    localparam int Z_BIT   = 30;
    localparam int C_BIT   = 29;
    localparam int V_BIT   = 28;
    localparam int I_BIT   = 7;
    localparam int F_BIT   = 6;
    localparam int T_BIT   = 5;
    localparam int MODE_HI = 4;
    localparam int MODE_LO = 0;

    // SPSR bank indices
    localparam logic [2:0] BANK_FIQ = 3'd0;
    localparam logic [2:0] BANK_IRQ = 3'd1;
    localparam logic [2:0] BANK_SVC = 3'd2;
    localparam logic [2:0] BANK_ABT = 3'd3;
    localparam logic [2:0] BANK_UND = 3'd4;
    localparam int         NUM_BANKS = 5;

    // SVC mode, IRQ and FIQ masked, ARM state, flags clear
    localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

    function automatic logic mode_valid(input logic [4:0] mode);
        case (mode)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: mode_valid = 1'b1;
            default:                      mode_valid = 1'b0;
        endcase
    endfunction

    // Byte-lane merge; mask[3] selects [31:24] down to mask[0] for [7:0].
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/psr_mode_decode.sv
// psr_mode_decode
// Combinational classification of a 5-bit processor mode field.
// Ports:
//   mode       in   5  mode encoding to classify
//   valid      out  1  encoding is one of the seven defined modes
//   privileged out  1  valid and not USR
//   has_spsr   out  1  mode owns a banked SPSR (FIQ, IRQ, SVC, ABT, UND)
//   bank_idx   out  3  SPSR bank index; only meaningful when has_spsr
module psr_mode_decode
    import psr_pkg::*;
(
    input  logic [4:0] mode,
    output logic       valid,
    output logic       privileged,
    output logic       has_spsr,
    output logic [2:0] bank_idx
);

    always_comb begin
        valid      = 1'b1;
        privileged = 1'b1;
        has_spsr   = 1'b1;
        bank_idx   = BANK_FIQ;
        case (mode)
            MODE_USR: begin
                privileged = 1'b0;
                has_spsr   = 1'b0;
            end
            MODE_SYS: has_spsr = 1'b0;
            MODE_FIQ: bank_idx = BANK_FIQ;
            MODE_IRQ: bank_idx = BANK_IRQ;
            MODE_SVC: bank_idx = BANK_SVC;
            MODE_ABT: bank_idx = BANK_ABT;
            MODE_UND: bank_idx = BANK_UND;
            default: begin
                valid      = 1'b0;
                privileged = 1'b0;
                has_spsr   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/psr_unit.sv
// psr_unit
// CPSR plus the five banked SPSRs of the core. All updates land on the
// rising edge after their strobe; cpsr is purely registered, spsr is a
// combinational read of the bank selected by the current mode.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpsr                current CPSR (registered)
//   spsr                SPSR of the current mode, or cpsr when the mode has none
//   flag_we, flags_in   NZCV load {N,Z,C,V}
//   t_we, t_in          Thumb bit load (BX)
//   msr_we, msr_spsr,   MSR write: target select, field mask {f,s,x,c},
//   msr_mask, msr_data  operand
//   exc_en, exc_mode,   exception entry into exc_mode, optionally setting F
//   exc_fiq_dis
//   restore             CPSR <= current SPSR
// Strobe priority: exc_en > restore > msr_we > {flag_we, t_we}.
module psr_unit
    import psr_pkg::*;
#(
    parameter logic [31:0] RESET_CPSR = RESET_CPSR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] cpsr,
    output logic [31:0] spsr,
    input  logic        flag_we,
    input  logic [3:0]  flags_in,
    input  logic        t_we,
    input  logic        t_in,
    input  logic        msr_we,
    input  logic        msr_spsr,
    input  logic [3:0]  msr_mask,
    input  logic [31:0] msr_data,
    input  logic        exc_en,
    input  logic [4:0]  exc_mode,
    input  logic        exc_fiq_dis,
    input  logic        restore
);

    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] spsr_bank [NUM_BANKS];

    logic        spsr_we;
    logic [2:0]  spsr_widx;
    logic [31:0] spsr_wdata;

    logic        cur_valid, cur_priv, cur_has_spsr;
    logic [2:0]  cur_idx;
    logic        exc_valid, exc_priv, exc_has_spsr;
    logic [2:0]  exc_idx;

    logic [31:0] cur_spsr;
    logic        cur_priv_ok;
    logic        exc_ok;
    logic [3:0]  cpsr_msr_mask;
    logic [31:0] msr_cpsr_val;
    logic [31:0] restore_val;

    psr_mode_decode u_cur_decode (
        .mode       (cpsr_q[MODE_HI:MODE_LO]),
        .valid      (cur_valid),
        .privileged (cur_priv),
        .has_spsr   (cur_has_spsr),
        .bank_idx   (cur_idx)
    );

    psr_mode_decode u_exc_decode (
        .mode       (exc_mode),
        .valid      (exc_valid),
        .privileged (exc_priv),
        .has_spsr   (exc_has_spsr),
        .bank_idx   (exc_idx)
    );

    assign cur_spsr    = cur_has_spsr ? spsr_bank[cur_idx] : cpsr_q;
    assign cur_priv_ok = cur_valid & cur_priv;
    // Exception targets must own an SPSR; USR, SYS and invalid codes are ignored.
    assign exc_ok      = exc_valid & exc_priv & exc_has_spsr;

    // In USR (or an invalid mode) MSR may only touch the flag byte.
    assign cpsr_msr_mask = cur_priv_ok ? msr_mask : {msr_mask[3], 3'b000};

    always_comb begin
        msr_cpsr_val        = byte_merge(cpsr_q, msr_data, cpsr_msr_mask);
        // T only changes through BX or exception entry, never through MSR.
        msr_cpsr_val[T_BIT] = cpsr_q[T_BIT];
        if (!mode_valid(msr_cpsr_val[MODE_HI:MODE_LO]))
            msr_cpsr_val[MODE_HI:MODE_LO] = cpsr_q[MODE_HI:MODE_LO];
    end

    always_comb begin
        restore_val = cur_spsr;
        if (!mode_valid(cur_spsr[MODE_HI:MODE_LO]))
            restore_val[MODE_HI:MODE_LO] = cpsr_q[MODE_HI:MODE_LO];
    end

    always_comb begin
        cpsr_d     = cpsr_q;
        spsr_we    = 1'b0;
        spsr_widx  = '0;
        spsr_wdata = '0;
        if (exc_en) begin
            if (exc_ok) begin
                spsr_we                 = 1'b1;
                spsr_widx               = exc_idx;
                spsr_wdata              = cpsr_q;
                cpsr_d[MODE_HI:MODE_LO] = exc_mode;
                cpsr_d[T_BIT]           = 1'b0;
                cpsr_d[I_BIT]           = 1'b1;
                if (exc_fiq_dis) cpsr_d[F_BIT] = 1'b1;
            end
        end else if (restore) begin
            if (cur_has_spsr) cpsr_d = restore_val;
        end else if (msr_we) begin
            if (!msr_spsr) begin
                cpsr_d = msr_cpsr_val;
            end else if (cur_has_spsr) begin
                spsr_we    = 1'b1;
                spsr_widx  = cur_idx;
                spsr_wdata = byte_merge(cur_spsr, msr_data, msr_mask);
            end
        end else begin
            if (flag_we) cpsr_d[N_BIT:V_BIT] = flags_in;
            if (t_we)    cpsr_d[T_BIT]       = t_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpsr_q <= RESET_CPSR;
        end else begin
            cpsr_q <= cpsr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) spsr_bank[i] <= '0;
        end else if (spsr_we) begin
            spsr_bank[spsr_widx] <= spsr_wdata;
        end
    end

    assign cpsr = cpsr_q;
    assign spsr = cur_spsr;

endmodule

// File: tb/tb_psr_unit.sv
module tb_psr_unit;

    logic        clk, rst;
    logic [31:0] cpsr, spsr;
    logic        flag_we;
    logic [3:0]  flags_in;
    logic        t_we, t_in;
    logic        msr_we, msr_spsr;
    logic [3:0]  msr_mask;
    logic [31:0] msr_data;
    logic        exc_en;
    logic [4:0]  exc_mode;
    logic        exc_fiq_dis;
    logic        restore;

    psr_unit dut (
        .clk(clk), .rst(rst), .cpsr(cpsr), .spsr(spsr),
        .flag_we(flag_we), .flags_in(flags_in), .t_we(t_we), .t_in(t_in),
        .msr_we(msr_we), .msr_spsr(msr_spsr), .msr_mask(msr_mask), .msr_data(msr_data),
        .exc_en(exc_en), .exc_mode(exc_mode), .exc_fiq_dis(exc_fiq_dis), .restore(restore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] c;
        logic [31:0] s;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_strobes();
        flag_we = 1'b0; flags_in = 4'h0; t_we = 1'b0; t_in = 1'b0;
        msr_we = 1'b0; msr_spsr = 1'b0; msr_mask = 4'h0; msr_data = 32'h0;
        exc_en = 1'b0; exc_mode = 5'h0; exc_fiq_dis = 1'b0; restore = 1'b0;
    endtask

    task automatic msr(input logic sp, input logic [3:0] m, input logic [31:0] d);
        msr_we = 1'b1; msr_spsr = sp; msr_mask = m; msr_data = d;
    endtask

    task automatic exc(input logic [4:0] m, input logic fd);
        exc_en = 1'b1; exc_mode = m; exc_fiq_dis = fd;
    endtask

    // Push the expectation, let one edge happen, then pop and compare.
    task automatic tick(input string tag, input logic [31:0] ec, input logic [31:0] es);
        exp_t e;
        e.tag = tag; e.c = ec; e.s = es;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".cpsr"}, cpsr, e.c);
        chk({e.tag, ".spsr"}, spsr, e.s);
        clear_strobes();
    endtask

    // ---------------- reference model for the random phase ----------------
    logic [31:0] m_cpsr;
    logic [31:0] m_bank [5];

    function automatic int bidx(input logic [4:0] m);
        case (m)
            5'b10001: return 0;
            5'b10010: return 1;
            5'b10011: return 2;
            5'b10111: return 3;
            5'b11011: return 4;
            default:  return -1;
        endcase
    endfunction

    function automatic bit valid_m(input logic [4:0] m);
        return (m == 5'b10000) || (m == 5'b11111) || (bidx(m) >= 0);
    endfunction

    function automatic logic [31:0] model_spsr();
        int k;
        k = bidx(m_cpsr[4:0]);
        return (k >= 0) ? m_bank[k] : m_cpsr;
    endfunction

    task automatic model_step();
        int k;
        logic [31:0] v;
        logic [4:0]  cur;
        bit          priv;
        cur = m_cpsr[4:0];
        if (exc_en) begin
            k = bidx(exc_mode);
            if (k >= 0) begin
                m_bank[k] = m_cpsr;
                m_cpsr = {m_cpsr[31:8], 1'b1, (exc_fiq_dis ? 1'b1 : m_cpsr[6]), 1'b0, exc_mode};
            end
        end else if (restore) begin
            k = bidx(cur);
            if (k >= 0) begin
                v = m_bank[k];
                m_cpsr = valid_m(v[4:0]) ? v : {v[31:5], cur};
            end
        end else if (msr_we) begin
            if (!msr_spsr) begin
                priv = valid_m(cur) && (cur != 5'b10000);
                v = m_cpsr;
                for (int i = 0; i < 4; i++)
                    if (msr_mask[i] && (i == 3 || priv)) v[i*8 +: 8] = msr_data[i*8 +: 8];
                v[5] = m_cpsr[5];
                if (!valid_m(v[4:0])) v[4:0] = cur;
                m_cpsr = v;
            end else begin
                k = bidx(cur);
                if (k >= 0)
                    for (int i = 0; i < 4; i++)
                        if (msr_mask[i]) m_bank[k][i*8 +: 8] = msr_data[i*8 +: 8];
            end
        end else begin
            if (flag_we) m_cpsr[31:28] = flags_in;
            if (t_we)    m_cpsr[5]     = t_in;
        end
    endtask

    logic [4:0] mode_pool [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        mode_pool[0] = 5'b10000; mode_pool[1] = 5'b10001; mode_pool[2] = 5'b10010;
        mode_pool[3] = 5'b10011; mode_pool[4] = 5'b10111; mode_pool[5] = 5'b11011;
        mode_pool[6] = 5'b11111; mode_pool[7] = 5'b10100; mode_pool[8] = 5'b00101;
        mode_pool[9] = 5'b11000;

        clear_strobes();
        rst = 1'b1;
        #12;
        chk("reset.cpsr", cpsr, 32'h0000_00D3);
        chk("reset.spsr", spsr, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        flag_we = 1; flags_in = 4'b0110;
        tick("flags0110", 32'h6000_00D3, 32'h0000_0000);
        msr(0, 4'b0001, 32'h0000_0030);
        tick("msr_to_usr", 32'h6000_0010, 32'h6000_0010);
        flag_we = 1; flags_in = 4'b0110; t_we = 1; t_in = 1;
        tick("flag_and_t", 32'h6000_0030, 32'h6000_0030);
        exc(5'b10010, 0);
        tick("irq_entry", 32'h6000_0092, 32'h6000_0030);
        restore = 1;
        tick("irq_restore", 32'h6000_0030, 32'h6000_0030);
        flag_we = 1; flags_in = 4'b0000; t_we = 1; t_in = 0;
        tick("usr_clear", 32'h0000_0010, 32'h0000_0010);
        msr(0, 4'b1001, 32'hF000_00D3);
        tick("usr_msr", 32'hF000_0010, 32'hF000_0010);
        exc(5'b10011, 0);
        tick("svc_entry", 32'hF000_0093, 32'hF000_0010);
        t_we = 1; t_in = 1;
        tick("svc_t1", 32'hF000_00B3, 32'hF000_0010);
        msr(0, 4'b1001, 32'hF000_00D3);
        tick("svc_msr_tkeep", 32'hF000_00F3, 32'hF000_0010);
        msr(0, 4'b1001, 32'h0000_0013);
        tick("svc_prep", 32'h0000_0033, 32'hF000_0010);
        t_we = 1; t_in = 0;
        tick("svc_t0", 32'h0000_0013, 32'hF000_0010);
        exc(5'b10001, 1); flag_we = 1; flags_in = 4'b1111;
        msr(0, 4'b1111, 32'hFFFF_FFFF); restore = 1;
        tick("collide_fiq", 32'h0000_00D1, 32'h0000_0013);
        restore = 1; msr(0, 4'b1111, 32'hFFFF_FFFF); flag_we = 1; flags_in = 4'b1111;
        tick("restore_prio", 32'h0000_0013, 32'hF000_0010);
        msr(0, 4'b1000, 32'hA000_0000); flag_we = 1; flags_in = 4'b1111; t_we = 1; t_in = 1;
        tick("msr_prio", 32'hA000_0013, 32'hF000_0010);
        msr(0, 4'b0001, 32'h0000_00E5);
        tick("msr_inv_mode", 32'hA000_00D3, 32'hF000_0010);
        exc(5'b10100, 1);
        tick("exc_inv_mode", 32'hA000_00D3, 32'hF000_0010);
        exc(5'b10000, 0);
        tick("exc_usr", 32'hA000_00D3, 32'hF000_0010);
        msr(1, 4'b0101, 32'h1234_5678);
        tick("msr_spsr_svc", 32'hA000_00D3, 32'hF034_0078);
        restore = 1;
        tick("restore_inv_mode", 32'hF034_0073, 32'hF034_0078);
        msr(0, 4'b0001, 32'h0000_001F);
        tick("to_sys", 32'hF034_003F, 32'hF034_003F);
        msr(1, 4'b1111, 32'h0000_0000);
        tick("sys_msr_spsr", 32'hF034_003F, 32'hF034_003F);
        restore = 1;
        tick("sys_restore", 32'hF034_003F, 32'hF034_003F);
        exc(5'b11111, 0);
        tick("exc_sys", 32'hF034_003F, 32'hF034_003F);
        exc(5'b10111, 1);
        tick("abt_entry", 32'hF034_00D7, 32'hF034_003F);
        exc(5'b11011, 0);
        tick("und_entry", 32'hF034_00DB, 32'hF034_00D7);

        // Asynchronous reset in the middle of a cycle, with strobes pending.
        #2;
        rst = 1'b1;
        flag_we = 1; flags_in = 4'b1111; exc(5'b10001, 1);
        #1;
        chk("async_rst.cpsr", cpsr, 32'h0000_00D3);
        chk("async_rst.spsr", spsr, 32'h0000_0000);
        @(posedge clk);
        #1;
        chk("rst_hold.cpsr", cpsr, 32'h0000_00D3);
        clear_strobes();
        @(negedge clk);
        rst = 1'b0;

        // Random strobe mix against the reference model.
        m_cpsr = 32'h0000_00D3;
        for (int i = 0; i < 5; i++) m_bank[i] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            exc_en      = ($urandom_range(0, 9) == 0);
            exc_mode    = mode_pool[$urandom_range(0, 9)];
            exc_fiq_dis = 1'($urandom_range(0, 1));
            restore     = ($urandom_range(0, 7) == 0);
            msr_we      = ($urandom_range(0, 3) == 0);
            msr_spsr    = 1'($urandom_range(0, 1));
            msr_mask    = 4'($urandom_range(0, 15));
            msr_data    = $urandom;
            if ($urandom_range(0, 1) == 1) msr_data[4:0] = mode_pool[$urandom_range(0, 9)];
            flag_we     = 1'($urandom_range(0, 1));
            flags_in    = 4'($urandom_range(0, 15));
            t_we        = 1'($urandom_range(0, 1));
            t_in        = 1'($urandom_range(0, 1));
            model_step();
            tick($sformatf("rand%0d", n), m_cpsr, model_spsr());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
